// File: rtl/aes_round_seq.sv
// Iterative AES encryption round sequencer: owns the state register, round counter
// and key index; the round datapath and key store sit outside this block.
module aes_round_seq #(
  parameter int unsigned DW = 128,
  parameter int unsigned NR = 10,
  parameter int unsigned KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [KW-1:0] key_idx,
  input  logic [DW-1:0] key_data,
  output logic [DW-1:0] rnd_in,
  output logic          rnd_last,
  input  logic [DW-1:0] rnd_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [KW-1:0] NR_K = KW'(NR);

  fsm_t          fsm, fsm_nxt;
  logic [DW-1:0] st, st_nxt;
  logic [KW-1:0] rnd, rnd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
      st  <= '0;
      rnd <= '0;
    end else begin
      fsm <= fsm_nxt;
      st  <= st_nxt;
      rnd <= rnd_nxt;
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    st_nxt  = st;
    rnd_nxt = rnd;
    // clear overrides every transition; the state register is left as is
    if (clear) begin
      fsm_nxt = IDLE;
      rnd_nxt = '0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            st_nxt  = in_data ^ key_data;
            rnd_nxt = KW'(1);
            fsm_nxt = RUN;
          end
        end
        RUN: begin
          st_nxt = rnd_out;
          if (rnd < NR_K) rnd_nxt = rnd + 1'b1;
          else            fsm_nxt = DONE;
        end
        DONE: begin
          if (out_ready) begin
            fsm_nxt = IDLE;
            rnd_nxt = '0;
          end
        end
        default: fsm_nxt = IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm == IDLE);
  assign key_idx   = (fsm == RUN) ? rnd : '0;
  assign rnd_in    = st;
  assign rnd_last  = (fsm == RUN) && (rnd == NR_K);
  assign out_valid = (fsm == DONE);
  assign out_data  = st;
  assign busy      = (fsm != IDLE);

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq with a behavioural AES-128 round datapath and key ROM.
module tb_aes_round_seq;
  localparam int unsigned DW = 128;
  localparam int unsigned NR = 10;
  localparam int unsigned KW = 4;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst_n, clear, in_valid, in_ready, rnd_last, out_valid, out_ready, busy;
  logic [DW-1:0] in_data, key_data, rnd_in, rnd_out, out_data;
  logic [KW-1:0] key_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit sb_en = 1'b0;

  logic [7:0]   sbox[256];
  logic [127:0] rk[16];
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  aes_round_seq #(.DW(DW), .NR(NR), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .key_data(key_data),
    .rnd_in(rnd_in), .rnd_last(rnd_last), .rnd_out(rnd_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] a[16];
    logic [7:0] b[16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr+4*((c+rr)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, rk[r], r == 10);
    return s;
  endfunction

  always_comb key_data = rk[key_idx];
  always_comb rnd_out  = aes_round(rnd_in, key_data, rnd_last);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] ex);
    checks++;
    assert (obs === ex) else begin
      failures++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, ex);
    end
  endtask

  // One negedge step; in stream mode every presented ciphertext is scored.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (sb_en && out_valid) begin
      chk("stream_pending", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) chk("stream_data", out_data, exp_q.pop_front());
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"},      busy,      1'b0);
    chk({tag, "_key_idx"},   key_idx,   '0);
    chk({tag, "_rnd_last"},  rnd_last,  1'b0);
    chk({tag, "_out_data"},  out_data,  '0);
  endtask

  // Accept one block from IDLE with out_ready high, then check the ciphertext.
  task automatic fips_run(input string tag);
    in_valid = 1'b1; in_data = FIPS_PT; out_ready = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_out_data"},  out_data,  FIPS_CT);
    tick();
    chk({tag, "_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [7:0]  inv[256];
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc, x;
    logic [127:0] pt;
    logic        seen_valid;
    int          last_acc, n;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    for (int i = 0; i < 256; i++) inv[i] = 8'h00;
    for (int i = 1; i < 256; i++)
      for (int j = 1; j < 256; j++)
        if (gmul(8'(i), 8'(j)) == 8'h01) inv[i] = 8'(j);
    for (int i = 0; i < 256; i++) begin
      x = inv[i];
      sbox[i] = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                  ^ {x[3:0], x[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = FIPS_KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 16; k++)
      rk[k] = (k <= 10) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : '0;

    // Reset values
    tick(); tick();
    chk_reset_outs("reset");
    rst_n = 1'b1;
    tick();

    // FIPS vector with per-cycle sequencing, then backpressure in DONE
    in_valid = 1'b1; in_data = FIPS_PT;
    chk("seq_idle_key_idx", key_idx, '0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      in_valid = 1'b0;
      chk($sformatf("seq_key_idx_%0d", c),  key_idx,   c[KW-1:0]);
      chk($sformatf("seq_rnd_last_%0d", c), rnd_last,  c == 10);
      chk($sformatf("seq_out_valid_%0d", c), out_valid, 1'b0);
      chk($sformatf("seq_in_ready_%0d", c), in_ready,  1'b0);
      chk($sformatf("seq_busy_%0d", c),     busy,      1'b1);
    end
    in_valid = 1'b1; in_data = 128'hdeadbeef_00000000_11111111_22222222;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("bp_out_valid_%0d", c), out_valid, 1'b1);
      chk($sformatf("bp_out_data_%0d", c),  out_data,  FIPS_CT);
      chk($sformatf("bp_in_ready_%0d", c),  in_ready,  1'b0);
      chk($sformatf("bp_key_idx_%0d", c),   key_idx,   '0);
      chk($sformatf("bp_rnd_last_%0d", c),  rnd_last,  1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_idle",   in_ready,  1'b1);
    chk("bp_release_valid",  out_valid, 1'b0);
    chk("bp_release_busy",   busy,      1'b0);

    // clear with in_valid in IDLE is not an accept
    clear = 1'b1; in_valid = 1'b1; in_data = FIPS_PT;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_idle_busy", busy, 1'b0);

    // clear on round 5
    in_valid = 1'b1; in_data = FIPS_PT; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 2; c <= 5; c++) tick();
    chk("clear_at_rnd5", key_idx, 4'd5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_in_ready",  in_ready, 1'b1);
    chk("clear_busy",      busy,     1'b0);
    chk("clear_key_idx",   key_idx,  '0);
    seen_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      seen_valid = seen_valid | out_valid;
    end
    chk("clear_no_out_valid", seen_valid, 1'b0);
    fips_run("after_clear");

    // async reset mid-RUN
    in_valid = 1'b1; in_data = FIPS_PT;
    tick();
    in_valid = 1'b0;
    for (int c = 2; c <= 4; c++) tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_outs("after_rst");
    fips_run("after_rst");

    // back-to-back random stream
    sb_en = 1'b1; out_ready = 1'b1; last_acc = 0;
    for (int v = 0; v < 1000; v++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1; in_data = pt;
      n = 0;
      while (!in_ready && n < 50) begin
        tick();
        n++;
      end
      if (n == 50) begin
        chk("stream_accept_timeout", in_ready, 1'b1);
        break;
      end
      exp_q.push_back(enc(pt));
      if (v > 0) chk("stream_spacing", 128'(cyc - last_acc), 128'd12);
      last_acc = cyc;
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) tick();
    chk("stream_drained", 128'(exp_q.size()), 128'd0);
    sb_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
